// File: rtl/stall_control_mc_if.sv
// Handshake bundle between the ID-stage hazard logic and the pipeline registers it steers.
// master = pipeline side that supplies the hazard inputs; slave = the stall control unit.
interface stall_control_mc_if #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
);
   logic             EX_MemRead;
   logic [REG_W-1:0] EX_rt;
   logic [REG_W-1:0] ID_rs;
   logic [REG_W-1:0] ID_rt;
   logic             ID_UseRs;
   logic             ID_UseRt;
   logic             Branch_Taken;
   logic             Mem_Busy;
   logic             Stats_Clr;
   logic             PC_WriteEn;
   logic             IFID_WriteEn;
   logic             Stall_flush;
   logic             IFID_Flush;
   logic             Pipe_Hold;
   logic [CNT_W-1:0] Stall_Count;

   modport master (
      output EX_MemRead, EX_rt, ID_rs, ID_rt, ID_UseRs, ID_UseRt,
      output Branch_Taken, Mem_Busy, Stats_Clr,
      input  PC_WriteEn, IFID_WriteEn, Stall_flush, IFID_Flush, Pipe_Hold, Stall_Count
   );

   modport slave (
      input  EX_MemRead, EX_rt, ID_rs, ID_rt, ID_UseRs, ID_UseRt,
      input  Branch_Taken, Mem_Busy, Stats_Clr,
      output PC_WriteEn, IFID_WriteEn, Stall_flush, IFID_Flush, Pipe_Hold, Stall_Count
   );
endinterface

// File: rtl/stall_control_mc.sv
// Multi-cycle load-use stall, memory-busy freeze and taken-branch flush control for a 5-stage pipeline.
// Optional bubble statistics counter enabled by defining STALL_STATS_EN.
module stall_control_mc #(
   parameter int REG_W      = 5,
   parameter int LOAD_STALL = 1,
   parameter int CNT_W      = 16
) (
   input logic                clk,
   input logic                rst_n,
   stall_control_mc_if.slave  bus
);
   localparam logic [0:0] ST_RUN    = 1'b0;
   localparam logic [0:0] ST_LSTALL = 1'b1;
   localparam logic       DET_EN    = (LOAD_STALL != 0);
   localparam logic       MULTI     = (LOAD_STALL > 1);
   localparam logic [3:0] LS_INIT   = 4'(LOAD_STALL - 1);

   logic [0:0] state_r;
   logic [0:0] state_nxt_s;
   logic [3:0] cnt_r;
   logic [3:0] cnt_nxt_s;
   logic       hz_s;
   logic       pc_we_s;
   logic       ifid_we_s;
   logic       stall_flush_s;
   logic       ifid_flush_s;
   logic       pipe_hold_s;

   // Load-use hazard against EX; r0 is hardwired zero and never conflicts.
   always_comb begin
      hz_s = DET_EN & bus.EX_MemRead & (bus.EX_rt != {REG_W{1'b0}}) &
             ((bus.ID_UseRs & (bus.EX_rt == bus.ID_rs)) |
              (bus.ID_UseRt & (bus.EX_rt == bus.ID_rt)));
   end

   // Output decode: reset, then memory freeze, then stall, then branch flush.
   always_comb begin
      pc_we_s       = 1'b1;
      ifid_we_s     = 1'b1;
      stall_flush_s = 1'b0;
      ifid_flush_s  = 1'b0;
      pipe_hold_s   = 1'b0;
      if (!rst_n) begin
         pc_we_s       = 1'b0;
         ifid_we_s     = 1'b0;
         stall_flush_s = 1'b1;
      end else if (bus.Mem_Busy) begin
         pc_we_s     = 1'b0;
         ifid_we_s   = 1'b0;
         pipe_hold_s = 1'b1;
      end else if ((state_r == ST_LSTALL) || hz_s) begin
         pc_we_s       = 1'b0;
         ifid_we_s     = 1'b0;
         stall_flush_s = 1'b1;
      end else begin
         ifid_flush_s = bus.Branch_Taken;
      end
   end

   // Next-state logic; the first bubble is issued from RUN, the rest counted down in LSTALL.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      if (bus.Mem_Busy) begin
         state_nxt_s = state_r;
         cnt_nxt_s   = cnt_r;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (hz_s && MULTI) begin
                  state_nxt_s = ST_LSTALL;
                  cnt_nxt_s   = LS_INIT;
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end
            ST_LSTALL: begin
               cnt_nxt_s = cnt_r - 4'd1;
               if (cnt_r == 4'd1) begin
                  state_nxt_s = ST_RUN;
               end else begin
                  state_nxt_s = ST_LSTALL;
               end
            end
            default: begin
               state_nxt_s = ST_RUN;
               cnt_nxt_s   = 4'd0;
            end
         endcase
      end
   end

   // FSM state and remaining-bubble counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_RUN;
         cnt_r   <= 4'd0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   assign bus.PC_WriteEn   = pc_we_s;
   assign bus.IFID_WriteEn = ifid_we_s;
   assign bus.Stall_flush  = stall_flush_s;
   assign bus.IFID_Flush   = ifid_flush_s;
   assign bus.Pipe_Hold    = pipe_hold_s;

`ifdef STALL_STATS_EN
   logic [CNT_W-1:0] stall_count_r;

   // Saturating bubble counter; a clear request wins over the increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count_r <= {CNT_W{1'b0}};
      end else if (bus.Stats_Clr) begin
         stall_count_r <= {CNT_W{1'b0}};
      end else if (stall_flush_s && !bus.Mem_Busy && (stall_count_r != {CNT_W{1'b1}})) begin
         stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_count_r <= stall_count_r;
      end
   end

   assign bus.Stall_Count = stall_count_r;
`else
   logic unused_stats_clr;

   assign unused_stats_clr = bus.Stats_Clr;
   assign bus.Stall_Count  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_stall_control_mc.sv
// Directed bench for stall_control_mc: LOAD_STALL=1 and 3 instances plus a 2-bit statistics instance.
module tb_stall_control_mc;
   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   stall_control_mc_if #(.REG_W(5), .CNT_W(16)) ifa ();
   stall_control_mc_if #(.REG_W(5), .CNT_W(16)) ifb ();
   stall_control_mc_if #(.REG_W(5), .CNT_W(2))  ifc ();

   stall_control_mc #(.REG_W(5), .LOAD_STALL(1), .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
   stall_control_mc #(.REG_W(5), .LOAD_STALL(3), .CNT_W(16)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
   stall_control_mc #(.REG_W(5), .LOAD_STALL(1), .CNT_W(2))  dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

   // {PC_WriteEn, IFID_WriteEn, Stall_flush, IFID_Flush, Pipe_Hold}
   logic [4:0] oa, ob;
   assign oa = {ifa.PC_WriteEn, ifa.IFID_WriteEn, ifa.Stall_flush, ifa.IFID_Flush, ifa.Pipe_Hold};
   assign ob = {ifb.PC_WriteEn, ifb.IFID_WriteEn, ifb.Stall_flush, ifb.IFID_Flush, ifb.Pipe_Hold};

   localparam logic [4:0] O_RST  = 5'b00100;
   localparam logic [4:0] O_RUN  = 5'b11000;
   localparam logic [4:0] O_STL  = 5'b00100;
   localparam logic [4:0] O_BR   = 5'b11010;
   localparam logic [4:0] O_BUSY = 5'b00001;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_a();
      ifa.EX_MemRead = 1'b0; ifa.EX_rt = 5'd0; ifa.ID_rs = 5'd0; ifa.ID_rt = 5'd0;
      ifa.ID_UseRs = 1'b0; ifa.ID_UseRt = 1'b0; ifa.Branch_Taken = 1'b0;
      ifa.Mem_Busy = 1'b0; ifa.Stats_Clr = 1'b0;
   endtask

   task automatic clear_b();
      ifb.EX_MemRead = 1'b0; ifb.EX_rt = 5'd0; ifb.ID_rs = 5'd0; ifb.ID_rt = 5'd0;
      ifb.ID_UseRs = 1'b0; ifb.ID_UseRt = 1'b0; ifb.Branch_Taken = 1'b0;
      ifb.Mem_Busy = 1'b0; ifb.Stats_Clr = 1'b0;
   endtask

   task automatic clear_c();
      ifc.EX_MemRead = 1'b0; ifc.EX_rt = 5'd0; ifc.ID_rs = 5'd0; ifc.ID_rt = 5'd0;
      ifc.ID_UseRs = 1'b0; ifc.ID_UseRt = 1'b0; ifc.Branch_Taken = 1'b0;
      ifc.Mem_Busy = 1'b0; ifc.Stats_Clr = 1'b0;
   endtask

   task automatic hazard_b();
      ifb.EX_MemRead = 1'b1; ifb.EX_rt = 5'b10010; ifb.ID_rs = 5'b10010; ifb.ID_UseRs = 1'b1;
   endtask

   initial begin
      logic [15:0] exp_cnt2;
      logic [15:0] exp_cnt5;
`ifdef STALL_STATS_EN
      exp_cnt2 = 16'd2;
      exp_cnt5 = 16'd3;
`else
      exp_cnt2 = 16'd0;
      exp_cnt5 = 16'd0;
`endif
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      clear_a();
      clear_b();
      clear_c();
      #3;
      chk("reset_outs_a", 16'(oa), 16'(O_RST));
      chk("reset_outs_b", 16'(ob), 16'(O_RST));
      chk("reset_count_a", ifa.Stall_Count, 16'd0);

      @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      chk("run_idle_a", 16'(oa), 16'(O_RUN));
      chk("run_idle_b", 16'(ob), 16'(O_RUN));

      // Classic load-use, LOAD_STALL=1
      next_cycle();
      ifa.EX_MemRead = 1'b1; ifa.EX_rt = 5'b10010; ifa.ID_rs = 5'b10010; ifa.ID_UseRs = 1'b1;
      #1;
      chk("ls1_bubble", 16'(oa), 16'(O_STL));
      next_cycle();
      clear_a();
      #1;
      chk("ls1_release", 16'(oa), 16'(O_RUN));
      next_cycle();
      #1;
      chk("ls1_no_residual", 16'(oa), 16'(O_RUN));

      // No match, r0, unused rt
      ifa.EX_MemRead = 1'b1; ifa.EX_rt = 5'b10000; ifa.ID_rs = 5'b10010; ifa.ID_rt = 5'b10010;
      ifa.ID_UseRs = 1'b1; ifa.ID_UseRt = 1'b1;
      #1;
      chk("no_match", 16'(oa), 16'(O_RUN));
      ifa.EX_rt = 5'd0; ifa.ID_rs = 5'd0; ifa.ID_rt = 5'd0;
      #1;
      chk("r0_no_hazard", 16'(oa), 16'(O_RUN));
      ifa.EX_rt = 5'd7; ifa.ID_rs = 5'd3; ifa.ID_rt = 5'd7; ifa.ID_UseRt = 1'b0;
      #1;
      chk("rt_unused", 16'(oa), 16'(O_RUN));
      ifa.ID_UseRt = 1'b1;
      #1;
      chk("rt_used", 16'(oa), 16'(O_STL));
      next_cycle();
      clear_a();

      // Branch flush with and without hazard
      ifa.Branch_Taken = 1'b1;
      #1;
      chk("branch_flush", 16'(oa), 16'(O_BR));
      next_cycle();
      ifa.Branch_Taken = 1'b0;
      #1;
      chk("branch_done", 16'(oa), 16'(O_RUN));
      ifa.Branch_Taken = 1'b1; ifa.EX_MemRead = 1'b1; ifa.EX_rt = 5'd9; ifa.ID_rs = 5'd9; ifa.ID_UseRs = 1'b1;
      #1;
      chk("branch_hz", 16'(oa), 16'(O_STL));
      ifa.Mem_Busy = 1'b1;
      #1;
      chk("busy_priority", 16'(oa), 16'(O_BUSY));
      next_cycle();
      clear_a();
      #1;
      chk("after_busy_a", 16'(oa), 16'(O_RUN));

      // Multi-cycle LOAD_STALL=3, with a branch arriving during LSTALL
      hazard_b();
      #1;
      chk("ls3_c1", 16'(ob), 16'(O_STL));
      next_cycle();
      clear_b();
      ifb.Branch_Taken = 1'b1;
      #1;
      chk("ls3_c2_branch_ignored", 16'(ob), 16'(O_STL));
      next_cycle();
      ifb.Branch_Taken = 1'b0;
      #1;
      chk("ls3_c3", 16'(ob), 16'(O_STL));
      next_cycle();
      #1;
      chk("ls3_c4_run", 16'(ob), 16'(O_RUN));

      // Mem_Busy in the middle of LOAD_STALL=3
      next_cycle();
      hazard_b();
      #1;
      chk("busy_c1", 16'(ob), 16'(O_STL));
      next_cycle();
      clear_b();
      #1;
      chk("busy_c2", 16'(ob), 16'(O_STL));
      next_cycle();
      ifb.Mem_Busy = 1'b1;
      #1;
      chk("busy_hold1", 16'(ob), 16'(O_BUSY));
      next_cycle();
      #1;
      chk("busy_hold2", 16'(ob), 16'(O_BUSY));
      next_cycle();
      ifb.Mem_Busy = 1'b0;
      #1;
      chk("busy_c3", 16'(ob), 16'(O_STL));
      next_cycle();
      #1;
      chk("busy_run", 16'(ob), 16'(O_RUN));

      // Reset asserted during LSTALL
      next_cycle();
      hazard_b();
      #1;
      next_cycle();
      clear_b();
      #1;
      chk("mid_stall", 16'(ob), 16'(O_STL));
      rst_n = 1'b0;
      #1;
      chk("mid_reset_outs", 16'(ob), 16'(O_RST));
      chk("mid_reset_count", ifb.Stall_Count, 16'd0);
      rst_n = 1'b1;
      #1;
      chk("post_reset_run", 16'(ob), 16'(O_RUN));
      next_cycle();
      #1;
      chk("post_reset_no_bubble", 16'(ob), 16'(O_RUN));

      // Statistics counter, CNT_W=2
      ifc.EX_MemRead = 1'b1; ifc.EX_rt = 5'd4; ifc.ID_rt = 5'd4; ifc.ID_UseRt = 1'b1;
      #1;
      chk("stats_start", 16'(ifc.Stall_Count), 16'd0);
      next_cycle();
      next_cycle();
      chk("stats_two", 16'(ifc.Stall_Count), exp_cnt2);
      next_cycle();
      next_cycle();
      next_cycle();
      chk("stats_sat", 16'(ifc.Stall_Count), exp_cnt5);
      ifc.Stats_Clr = 1'b1;
      next_cycle();
      chk("stats_clr_priority", 16'(ifc.Stall_Count), 16'd0);
      clear_c();
      next_cycle();
      chk("stats_idle", 16'(ifc.Stall_Count), 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/stall_control_mc.md
Name: stall_control_mc

Overview:
- Parametrised successor to the single-cycle load-use stall unit in the 5-stage MIPS pipeline; sits beside the ID stage.
- Detects load-use hazards against EX and inserts LOAD_STALL bubbles; a counter FSM holds the stall across multiple cycles.
- Adds a global memory-busy freeze and a taken-branch IF/ID flush.
- Drives the PC, IF/ID and ID/EX write enables, plus the ID/EX bubble control.

Parameters:
- REG_W, 5, register-specifier width.
- LOAD_STALL, 1, bubble cycles per load-use hazard (0..15); 0 disables load-use detection.
- CNT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous reset, active low.
- EX_MemRead  in  1  instruction in EX is a load.
- EX_rt  in  REG_W  load destination register in EX.
- ID_rs  in  REG_W  ID source register rs.
- ID_rt  in  REG_W  ID source register rt.
- ID_UseRs  in  1  ID instruction reads rs.
- ID_UseRt  in  1  ID instruction reads rt.
- Branch_Taken  in  1  branch resolved taken in ID.
- Mem_Busy  in  1  data memory not ready; freeze the whole pipeline.
- Stats_Clr  in  1  synchronous clear of Stall_Count.
- PC_WriteEn  out  1  PC may update.
- IFID_WriteEn  out  1  IF/ID may update.
- Stall_flush  out  1  zero the ID/EX control fields (bubble).
- IFID_Flush  out  1  replace the IF/ID instruction with a NOP.
- Pipe_Hold  out  1  hold ID/EX, EX/MEM and MEM/WB.
- Stall_Count  out  CNT_W  count of bubble cycles, saturating.

Behaviour:
- Reset (rst_n low, asynchronous): FSM=RUN, cnt=0, Stall_Count=0.
- Outputs forced while rst_n is low: PC_WriteEn=0, IFID_WriteEn=0, Stall_flush=1, IFID_Flush=0, Pipe_Hold=0.
- Hazard term: hz = (LOAD_STALL!=0) & EX_MemRead & (EX_rt!=0) & ((ID_UseRs & EX_rt==ID_rs) | (ID_UseRt & EX_rt==ID_rt)).
- Register 0 never causes a hazard.
- Outputs are combinational from FSM state and inputs (zero latency); only the FSM state, cnt and Stall_Count are registered.
- Priority is Mem_Busy, then stall, then branch.
- Mem_Busy=1, any state:
  - PC_WriteEn=0, IFID_WriteEn=0, Pipe_Hold=1, Stall_flush=0, IFID_Flush=0.
  - FSM state and cnt are frozen.
- RUN, Mem_Busy=0, hz=1:
  - PC_WriteEn=0, IFID_WriteEn=0, Stall_flush=1.
  - If LOAD_STALL>1: next state LSTALL, cnt<=LOAD_STALL-1. Otherwise stay in RUN.
- LSTALL, Mem_Busy=0:
  - PC_WriteEn=0, IFID_WriteEn=0, Stall_flush=1; cnt<=cnt-1.
  - When cnt==1, next state is RUN.
  - hz is ignored in LSTALL because EX already holds a bubble.
- RUN, Mem_Busy=0, hz=0:
  - PC_WriteEn=1, IFID_WriteEn=1, Stall_flush=0, Pipe_Hold=0.
  - IFID_Flush=Branch_Taken.
- Branch_Taken with hz=1, or while in LSTALL: ignored (IFID_Flush=0). The branch re-resolves when ID is released.
- Total bubbles per hazard = LOAD_STALL exactly, independent of any Mem_Busy cycles in between.
- Reset asserted mid-stall aborts immediately to RUN; no residual bubbles after release.

Optional Feature:
- Macro: STALL_STATS_EN.
- Defined:
  - Stall_Count increments on each clock where Stall_flush=1, Mem_Busy=0 and rst_n=1.
  - It saturates at all-ones.
  - Stats_Clr=1 clears it to 0 on the next edge and takes priority over the increment.
- Not defined: Stall_Count is tied to 0; Stats_Clr is ignored; no counter flops are inferred.

Test Plan:
- Classic load-use, LOAD_STALL=1: EX_MemRead=1, EX_rt=5'b10010, ID_rs=5'b10010, ID_UseRs=1 for one cycle, then EX cleared -> exactly 1 cycle of PC_WriteEn=0, IFID_WriteEn=0, Stall_flush=1, then 1/1/0.
- No match and r0 cases:
  - EX_rt=5'b10000, ID_rs=ID_rt=5'b10010 -> outputs 1/1/0.
  - EX_rt=0=ID_rs, ID_UseRs=1 -> no stall.
  - ID_rt match with ID_UseRt=0 -> no stall.
- Multi-cycle, LOAD_STALL=3: hazard pulse for one cycle -> Stall_flush=1 for exactly 3 cycles, FSM back in RUN on cycle 4.
- Mem_Busy for 2 cycles in the middle of the LOAD_STALL=3 sequence -> Pipe_Hold=1 and Stall_flush=0 for those 2 cycles; still exactly 3 bubble cycles in total.
- Branch:
  - Branch_Taken=1 with hz=0 -> IFID_Flush=1, PC_WriteEn=1 for 1 cycle.
  - Branch_Taken=1 with hz=1 -> IFID_Flush=0, stall taken.
- Stats, STALL_STATS_EN defined, CNT_W=2: 5 bubble cycles -> Stall_Count=3 (saturated). Stats_Clr=1 -> 0.
- Reset mid-stall: rst_n low during LSTALL -> Stall_Count=0, state=RUN, no bubbles after release.
